uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_ctrl_fifo.sv | 99 +++++++++
 rtl/uart_rx_ctrl.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding and
// default parameter values used by uart_rx_ctrl and its FIFO.
package uart_pkg;

    // Controller states. Only StRun and StBreak enable the receiver.
    typedef enum logic [1:0] {
        StDisabled = 2'd0,
        StRun      = 2'd1,
        StBreak    = 2'd2
    } rx_state_e;

    localparam int unsigned DefPayloadBits   = 8;
    localparam int unsigned DefFifoDepth     = 8;
    localparam int unsigned DefTimeoutCycles = 16;

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// First-word-fall-through receive buffer holding data plus a packet-last flag.
// A push into a full buffer is accepted only when a pop happens in the same
// cycle; otherwise it is dropped and the sticky overflow flag is set.
module uart_rx_ctrl_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = DefPayloadBits,
    parameter int unsigned DEPTH = DefFifoDepth
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     push_last,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     pop_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int unsigned AddrW = $clog2(DEPTH);

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0] last_mem;

    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   level_q, level_d;
    logic             overflow_q, overflow_d;

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;
    logic drop;

    assign full    = (level_q == (AddrW + 1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot this push needs.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    // Pointer, level and overflow next-state; pointers wrap at power-of-two depth.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // Set wins over a simultaneous clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage write; contents need no reset because outputs are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[wr_ptr_q] <= push_data;
            last_mem[wr_ptr_q] <= push_last;
        end
    end

    assign pop_data = empty ? '0 : data_mem[rd_ptr_q];
    assign pop_last = empty ? 1'b0 : last_mem[rd_ptr_q];
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: gates the receiver, filters break bytes and buffers
// accepted bytes in a FWFT FIFO for a valid/ready consumer.
// Define UART_RX_CTRL_TIMEOUT_EN to delimit packets: bytes pass through a
// one-entry staging register and the last byte of a packet (idle timeout,
// break or disable) is marked with m_last. Without it, m_last is always 0.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS   = DefPayloadBits,
    parameter int unsigned FIFO_DEPTH     = DefFifoDepth,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ctrl_en,
    output logic                          uart_rx_en,
    input  logic                          uart_rx_valid,
    input  logic                          uart_rx_break,
    input  logic [PAYLOAD_BITS-1:0]       uart_rx_data,
    output logic [PAYLOAD_BITS-1:0]       m_data,
    output logic                          m_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          break_seen
);

    rx_state_e state_q, state_d;
    logic      break_seen_q, break_seen_d;

    logic                    accept;
    logic                    break_in_run;
    logic                    push;
    logic [PAYLOAD_BITS-1:0] push_data;
    logic                    push_last;
    logic                    fifo_last;

    assign accept       = uart_rx_valid & ~uart_rx_break & (state_q != StDisabled);
    assign break_in_run = uart_rx_valid & uart_rx_break & (state_q == StRun);

    // FSM next state; disabling overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StDisabled: begin
                if (ctrl_en) state_d = StRun;
            end
            StRun: begin
                if (!ctrl_en) begin
                    state_d = StDisabled;
                end else if (uart_rx_valid && uart_rx_break) begin
                    state_d = StBreak;
                end
            end
            StBreak: begin
                if (!ctrl_en) begin
                    state_d = StDisabled;
                end else if (uart_rx_valid && !uart_rx_break) begin
                    state_d = StRun;
                end
            end
            default: state_d = StDisabled;
        endcase
        // Pulse only on entering StBreak, not for repeated break bytes.
        break_seen_d = break_in_run & ctrl_en;
    end

    // FSM state and break pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StDisabled;
            break_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            break_seen_q <= break_seen_d;
        end
    end

    assign uart_rx_en = (state_q != StDisabled);
    assign break_seen = break_seen_q;

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

    logic                    stage_vld_q, stage_vld_d;
    logic [PAYLOAD_BITS-1:0] stage_data_q, stage_data_d;
    logic [IdleW-1:0]        idle_q, idle_d;

    // Staging: a new byte displaces the staged one (not last); an idle
    // timeout, break or disable flushes the staged byte as packet end.
    always_comb begin
        stage_vld_d  = stage_vld_q;
        stage_data_d = stage_data_q;
        idle_d       = idle_q;
        push         = 1'b0;
        push_data    = stage_data_q;
        push_last    = 1'b0;
        if (accept) begin
            push         = stage_vld_q;
            stage_vld_d  = 1'b1;
            stage_data_d = uart_rx_data;
            idle_d       = '0;
        end else if (stage_vld_q) begin
            if (break_in_run || !ctrl_en || idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
                push        = 1'b1;
                push_last   = 1'b1;
                stage_vld_d = 1'b0;
                idle_d      = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    // Staging and idle counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_vld_q  <= 1'b0;
            stage_data_q <= '0;
            idle_q       <= '0;
        end else begin
            stage_vld_q  <= stage_vld_d;
            stage_data_q <= stage_data_d;
            idle_q       <= idle_d;
        end
    end

    assign m_last = fifo_last;
`else
    // Accepted bytes go straight into the FIFO, visible the next cycle.
    assign push      = accept;
    assign push_data = uart_rx_data;
    assign push_last = 1'b0;
    assign m_last    = 1'b0;

    logic unused_cfg;
    assign unused_cfg = fifo_last ^ (^TIMEOUT_CYCLES);
`endif

    uart_rx_ctrl_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_data    (push_data),
        .push_last    (push_last),
        .pop          (m_valid & m_ready),
        .pop_data     (m_data),
        .pop_last     (fifo_last),
        .level        (fifo_level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    assign m_valid = (fifo_level != '0);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus a random
// phase, all compared against a queue-based reference model of the controller.
module tb_uart_rx_ctrl;

    localparam int unsigned PB    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TOC   = 16;
`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ctrl_en;
    logic          uart_rx_en;
    logic          uart_rx_valid;
    logic          uart_rx_break;
    logic [PB-1:0] uart_rx_data;
    logic [PB-1:0] m_data;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic [3:0]    fifo_level;
    logic          overflow;
    logic          overflow_clr;
    logic          break_seen;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [8:0]    ref_q[$];     // {last, data}
    bit            ref_ovf;
    bit            ref_en;       // receiver enabled
    bit            ref_inbrk;    // inside a break run
    bit            ref_pulse;
    bit            ref_stg_v;
    logic [PB-1:0] ref_stg_d;
    int            ref_idle;
    logic [PB-1:0] popped[$];

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .PAYLOAD_BITS   (PB),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ctrl_en       (ctrl_en),
        .uart_rx_en    (uart_rx_en),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_break (uart_rx_break),
        .uart_rx_data  (uart_rx_data),
        .m_data        (m_data),
        .m_last        (m_last),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr),
        .break_seen    (break_seen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_q.delete();
        ref_ovf   = 1'b0;
        ref_en    = 1'b0;
        ref_inbrk = 1'b0;
        ref_pulse = 1'b0;
        ref_stg_v = 1'b0;
        ref_stg_d = '0;
        ref_idle  = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit         pop, acc, brk_run, have_push, dropped;
        logic [8:0] pv;
        pop       = (ref_q.size() != 0) && m_ready;
        acc       = uart_rx_valid && !uart_rx_break && ref_en;
        brk_run   = uart_rx_valid && uart_rx_break && ref_en && !ref_inbrk;
        have_push = 1'b0;
        dropped   = 1'b0;
        pv        = '0;
        if (TO_EN) begin
            if (acc) begin
                if (ref_stg_v) begin
                    have_push = 1'b1;
                    pv        = {1'b0, ref_stg_d};
                end
                ref_stg_v = 1'b1;
                ref_stg_d = uart_rx_data;
                ref_idle  = 0;
            end else if (ref_stg_v) begin
                ref_idle++;
                if (brk_run || !ctrl_en || ref_idle == int'(TOC)) begin
                    have_push = 1'b1;
                    pv        = {1'b1, ref_stg_d};
                    ref_stg_v = 1'b0;
                    ref_idle  = 0;
                end
            end
        end else if (acc) begin
            have_push = 1'b1;
            pv        = {1'b0, uart_rx_data};
        end
        if (pop) void'(ref_q.pop_front());
        if (have_push) begin
            if (ref_q.size() < int'(DEPTH)) ref_q.push_back(pv);
            else dropped = 1'b1;
        end
        if (dropped) ref_ovf = 1'b1;
        else if (overflow_clr) ref_ovf = 1'b0;
        ref_pulse = brk_run && ctrl_en;
        if (!ctrl_en) begin
            ref_en    = 1'b0;
            ref_inbrk = 1'b0;
        end else if (!ref_en) begin
            ref_en = 1'b1;
        end else if (brk_run) begin
            ref_inbrk = 1'b1;
        end else if (ref_inbrk && acc) begin
            ref_inbrk = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [8:0] head;
        head = (ref_q.size() != 0) ? ref_q[0] : 9'h0;
        chk({tag, ".m_valid"},    m_valid,    ref_q.size() != 0);
        chk({tag, ".fifo_level"}, fifo_level, ref_q.size());
        chk({tag, ".m_data"},     m_data,     head[7:0]);
        chk({tag, ".m_last"},     m_last,     head[8]);
        chk({tag, ".overflow"},   overflow,   ref_ovf);
        chk({tag, ".break_seen"}, break_seen, ref_pulse);
        chk({tag, ".uart_rx_en"}, uart_rx_en, ref_en);
    endtask

    // One clock: update model, record a pop, take the edge, compare after it.
    task automatic cyc(input string tag);
        if (m_valid && m_ready) popped.push_back(m_data);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic send(input logic [7:0] d, input bit brk, input string tag);
        uart_rx_valid = 1'b1;
        uart_rx_break = brk;
        uart_rx_data  = d;
        cyc(tag);
        uart_rx_valid = 1'b0;
        uart_rx_break = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    initial begin
        reset         = 1'b1;
        ctrl_en       = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_break = 1'b0;
        uart_rx_data  = '0;
        m_ready       = 1'b0;
        overflow_clr  = 1'b0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.m_valid", m_valid, 0);
        chk("rst.fifo_level", fifo_level, 0);
        chk("rst.m_data", m_data, 0);
        chk("rst.m_last", m_last, 0);
        chk("rst.overflow", overflow, 0);
        chk("rst.break_seen", break_seen, 0);
        chk("rst.uart_rx_en", uart_rx_en, 0);
        reset = 1'b0;
        cyc("idle_dis");

        // Bytes in DISABLED are ignored; enable takes effect next cycle.
        send(8'h99, 1'b0, "dis_byte");
        ctrl_en = 1'b1;
        cyc("enable");
        chk("enable.uart_rx_en", uart_rx_en, 1);

        // In-order delivery.
        m_ready = 1'b1;
        popped.delete();
        send(8'h41, 1'b0, "b41");
        send(8'h42, 1'b0, "b42");
        idle(TOC + 4, "drain1");
        chk("order.count", popped.size(), 2);
        chk("order.first", popped[0], 8'h41);
        chk("order.second", popped[1], 8'h42);

        // Overflow on the ninth byte, then clear.
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(8'h60 + 8'(i), 1'b0, "fill");
        idle(TOC + 4, "fill_wait");
        chk("ovf.level", fifo_level, 8);
        chk("ovf.flag", overflow, 1);
        chk("ovf.head", m_data, 8'h60);
        overflow_clr = 1'b1;
        cyc("ovf_clr");
        overflow_clr = 1'b0;
        chk("ovf.cleared", overflow, 0);

        // Push and pop together while full.
        if (TO_EN) send(8'h77, 1'b0, "stage77");
        m_ready = 1'b1;
        send(8'h78, 1'b0, "full_pushpop");
        chk("fullpp.level", fifo_level, 8);
        chk("fullpp.overflow", overflow, 0);
        idle(TOC + 12, "drain2");
        chk("drain2.level", fifo_level, 0);

        // Break handling.
        m_ready = 1'b0;
        send(8'h00, 1'b1, "brk");
        chk("brk.pulse", break_seen, 1);
        send(8'h55, 1'b0, "after_brk");
        chk("brk.pulse_once", break_seen, 0);
        idle(TOC + 4, "brk_wait");
        chk("brk.level", fifo_level, 1);
        chk("brk.data", m_data, 8'h55);
        send(8'h00, 1'b1, "brk2");
        chk("brk.back_in_run", break_seen, 1);
        send(8'h56, 1'b0, "after_brk2");
        m_ready = 1'b1;
        idle(TOC + 4, "drain3");

        // Packet delimiting.
        m_ready = 1'b0;
        send(8'h10, 1'b0, "p10");
        chk("pkt.level_after_10", fifo_level, TO_EN ? 0 : 1);
        send(8'h11, 1'b0, "p11");
        chk("pkt.level_after_11", fifo_level, TO_EN ? 1 : 2);
        chk("pkt.head", m_data, 8'h10);
        idle(TOC, "pkt_idle");
        chk("pkt.level", fifo_level, 2);
        chk("pkt.last0", m_last, 0);
        m_ready = 1'b1;
        cyc("pkt_pop");
        chk("pkt.second", m_data, 8'h11);
        chk("pkt.last1", m_last, TO_EN);
        idle(3, "drain4");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            uart_rx_valid = ($urandom_range(0, 99) < 55);
            uart_rx_break = ($urandom_range(0, 99) < 6);
            uart_rx_data  = 8'($urandom);
            m_ready       = ($urandom_range(0, 99) < 45);
            overflow_clr  = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 3) ctrl_en = ~ctrl_en;
            if (i % 150 < 20) uart_rx_valid = 1'b0;
            cyc("rand");
        end
        uart_rx_valid = 1'b0;
        uart_rx_break = 1'b0;
        overflow_clr  = 1'b0;
        ctrl_en       = 1'b1;
        m_ready       = 1'b0;
        idle(2, "settle");

        // Reset with bytes buffered empties the FIFO at once.
        send(8'hA1, 1'b0, "r1");
        send(8'hA2, 1'b0, "r2");
        send(8'hA3, 1'b0, "r3");
        send(8'hA4, 1'b0, "r4");
        reset = 1'b1;
        #1;
        chk("midrst.m_valid", m_valid, 0);
        chk("midrst.fifo_level", fifo_level, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("midrst_hold");
        idle(TOC + 4, "post_rst");
        chk("post_rst.level", fifo_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
